// File: rtl/smart_home_pkg.sv
// Shared types and sizing helpers for the smart lighting blocks.
// Channel state encoding and counter width derivations.
package smart_home_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ch_state_e;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_level(input int dim_w);
        return (1 << dim_w) - 1;
    endfunction

endpackage

// File: rtl/smart_light_channel.sv
// One dimmable lamp channel: ramp prescaler, level register, idle timer.
// Requests arrive already qualified by the shared lock.
module smart_light_channel
    import smart_home_pkg::*;
#(
    parameter int DIM_W    = 3,
    parameter int RAMP_CYC = 4,
    parameter int IDLE_CYC = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_i,
    input  logic             off_i,
    input  logic             all_off_i,
    input  logic             motion_i,
    output logic [DIM_W-1:0] level_o,
    output logic             busy_o,
    output logic             timeout_evt_o
);

    localparam int PW = cnt_w(RAMP_CYC);
    localparam int IW = cnt_w(IDLE_CYC + 1);
    localparam logic [DIM_W-1:0] MAX_LVL = DIM_W'(max_level(DIM_W));
    localparam logic [PW-1:0] PRE_TOP = PW'(RAMP_CYC - 1);
    localparam logic [IW-1:0] IDLE_LD = IW'(IDLE_CYC);
    localparam bit IDLE_EN = (IDLE_CYC != 0);

    ch_state_e        state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [DIM_W-1:0] lvl_q, lvl_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             tev_q, tev_d;

    logic [DIM_W-1:0] lvl_up, lvl_dn;
    logic             step, kill, start, expire;

    assign step   = (pre_q == PRE_TOP);
    assign lvl_up = (lvl_q == MAX_LVL) ? MAX_LVL : lvl_q + 1'b1;
    assign lvl_dn = (lvl_q == '0) ? '0 : lvl_q - 1'b1;
    assign kill   = off_i | all_off_i;
    assign start  = on_i & ~kill;
    // Motion in the final idle cycle rescues the lamp.
    assign expire = IDLE_EN && (state_q == ST_ON) && !motion_i
                    && (idle_q == IW'(1));

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        lvl_d   = lvl_q;
        idle_d  = idle_q;
        tev_d   = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (start) begin
                    state_d = ST_RAMP_UP;
                    pre_d   = '0;
                end
            end
            ST_RAMP_UP: begin
                if (kill) begin
                    state_d = ST_RAMP_DOWN;
                    pre_d   = '0;
                end else if (step) begin
                    pre_d = '0;
                    lvl_d = lvl_up;
                    if (lvl_up == MAX_LVL) begin
                        state_d = ST_ON;
                        idle_d  = IDLE_LD;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_ON: begin
                if (kill || expire) begin
                    state_d = ST_RAMP_DOWN;
                    pre_d   = '0;
                    tev_d   = expire;
                end else if (IDLE_EN) begin
                    idle_d = motion_i ? IDLE_LD : idle_q - 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                if (start) begin
                    state_d = ST_RAMP_UP;
                    pre_d   = '0;
                end else if (step) begin
                    pre_d = '0;
                    lvl_d = lvl_dn;
                    if (lvl_dn == '0) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            pre_q   <= '0;
            lvl_q   <= '0;
            idle_q  <= '0;
            tev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            lvl_q   <= lvl_d;
            idle_q  <= idle_d;
            tev_q   <= tev_d;
        end
    end

    assign level_o       = lvl_q;
    assign busy_o        = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign timeout_evt_o = tev_q;

endmodule

// File: rtl/smart_light_array_ctrl.sv
// Multi-channel lamp controller with a shared keypad lock window.
// all_off bypasses the lock and fans out to every channel.
module smart_light_array_ctrl
    import smart_home_pkg::*;
#(
    parameter int NUM_LAMPS = 4,
    parameter int DIM_W     = 3,
    parameter int RAMP_CYC  = 4,
    parameter int ARM_CYC   = 64,
    parameter int IDLE_CYC  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       keypad_ok,
    input  logic [NUM_LAMPS-1:0]       on_req,
    input  logic [NUM_LAMPS-1:0]       off_req,
    input  logic [NUM_LAMPS-1:0]       motion,
    input  logic                       all_off,
    output logic                       locked,
    output logic [NUM_LAMPS*DIM_W-1:0] lamp_level,
    output logic [NUM_LAMPS-1:0]       lamp_on,
    output logic [NUM_LAMPS-1:0]       busy,
    output logic [NUM_LAMPS-1:0]       timeout_evt
);

    localparam int AW = cnt_w(ARM_CYC + 1);
    localparam logic [AW-1:0] ARM_LD = AW'(ARM_CYC);

    logic [AW-1:0]        lock_q, lock_d;
    logic [NUM_LAMPS-1:0] on_g, off_g;

    assign locked = (lock_q == '0);
    assign on_g   = locked ? '0 : on_req;
    assign off_g  = locked ? '0 : off_req;

    // Only accepted requests keep the window open.
    always_comb begin
        lock_d = lock_q;
        if (keypad_ok || (|on_g) || (|off_g)) begin
            lock_d = ARM_LD;
        end else if (!locked) begin
            lock_d = lock_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_ch
        smart_light_channel #(
            .DIM_W    (DIM_W),
            .RAMP_CYC (RAMP_CYC),
            .IDLE_CYC (IDLE_CYC)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .on_i          (on_g[i]),
            .off_i         (off_g[i]),
            .all_off_i     (all_off),
            .motion_i      (motion[i]),
            .level_o       (lamp_level[i*DIM_W +: DIM_W]),
            .busy_o        (busy[i]),
            .timeout_evt_o (timeout_evt[i])
        );
        assign lamp_on[i] = |lamp_level[i*DIM_W +: DIM_W];
    end

endmodule

// File: doc/smart_light_array_ctrl.md
Name: smart_light_array_ctrl

Overview:
- Multi-channel successor to the single-lamp light controller: NUM_LAMPS independent lamp channels, each with dimmable brightness ramping, an auto-off idle timer and motion retrigger.
- All channels share a keypad-authorised lock window; a global all-off safety input overrides the lock.
- Sits between the keypad/button front-end (synchronised single-cycle pulses) and the lamp PWM drivers, which consume lamp_level.

Parameters:
NUM_LAMPS, 4, number of lamp channels
DIM_W, 3, brightness width; MAX_LEVEL = 2**DIM_W-1
RAMP_CYC, 4, cycles per one-step brightness change (>=1)
ARM_CYC, 64, lock window length in cycles after authorisation or accepted command (>=1)
IDLE_CYC, 32, auto-off timeout in ON state; 0 disables auto-off

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
keypad_ok  in  1  one-cycle pulse, valid keypad code entered
on_req  in  NUM_LAMPS  per-channel turn-on request pulse
off_req  in  NUM_LAMPS  per-channel turn-off request pulse
motion  in  NUM_LAMPS  per-channel occupancy pulse; reloads idle timer
all_off  in  1  global off pulse, honoured even when locked
locked  out  1  1 = on_req/off_req ignored
lamp_level  out  NUM_LAMPS*DIM_W  channel i brightness in bits [i*DIM_W +: DIM_W]
lamp_on  out  NUM_LAMPS  lamp_level[i] != 0
busy  out  NUM_LAMPS  channel i in RAMP_UP or RAMP_DOWN
timeout_evt  out  NUM_LAMPS  one-cycle pulse when idle timer forces ramp-down

Behaviour:
- Reset (asynchronous, any time incl. mid-ramp): locked=1, lock counter 0, every channel OFF, lamp_level=0, lamp_on=0, busy=0, timeout_evt=0, prescalers and idle timers 0. All outputs registered or decoded from registers only; no combinational input-to-output path.
- Lock: keypad_ok at edge t -> locked=0 after t, lock counter=ARM_CYC. Counter decrements each cycle while unlocked; locked=1 on the edge it reaches 0. Any keypad_ok, or any on_req/off_req bit sampled while unlocked, reloads ARM_CYC. Requests sampled while locked=1 are dropped, not queued; the keypad_ok edge itself does not unlock same-cycle requests.
- Channel FSM states: OFF, RAMP_UP, ON, RAMP_DOWN.
- OFF + on_req (unlocked) -> RAMP_UP.
- RAMP_UP: prescaler cleared on entry, increments each cycle; when prescaler==RAMP_CYC-1, level += 1 and prescaler clears. Level reaching MAX_LEVEL -> ON on the same edge.
- ON: idle timer loaded with IDLE_CYC on entry, decrements each cycle; motion[i] reloads it. Reaching 0 -> RAMP_DOWN with timeout_evt[i]=1 for exactly that cycle. IDLE_CYC=0: timer inactive, channel stays ON.
- RAMP_UP or ON + off_req (unlocked) -> RAMP_DOWN. RAMP_DOWN steps level -1 with the same prescaler rule; level reaching 0 -> OFF.
- RAMP_DOWN + on_req (unlocked) -> RAMP_UP from the current level; prescaler cleared.
- Redundant requests (on_req in RAMP_UP/ON, off_req in OFF/RAMP_DOWN) change no state but still reload the lock counter.
- Simultaneous on_req and off_req on one channel: off wins.
- all_off: every channel not in OFF -> RAMP_DOWN regardless of locked. Beats on_req in the same cycle. Does not reload the lock counter.
- Idle expiry and off_req in the same cycle: single transition to RAMP_DOWN, timeout_evt asserted.
- Level never wraps: saturates at 0 and MAX_LEVEL.
- Channels are fully independent apart from the shared lock and all_off.

Decomposition:
- Shared package smart_home_pkg: channel state enum (OFF=2'd0, RAMP_UP=2'd1, ON=2'd2, RAMP_DOWN=2'd3), MAX_LEVEL derivation, clog2-based counter widths for RAMP_CYC/ARM_CYC/IDLE_CYC.
- Sub-module smart_light_channel: one FSM with prescaler, level register and idle timer. Instantiated NUM_LAMPS times via generate. The top holds the lock counter, gates on_req/off_req with !locked and fans out all_off.

Test Plan:
- Reset, then on_req[0] with no keypad_ok -> locked=1, lamp_level=0 throughout, no state change.
- keypad_ok at t, on_req[0] at t+1 -> busy[0]=1; level 1 at t+5, level 7 and ON at t+29, busy[0]=0, lamp_on[0]=1.
- Channel 1 ON, no motion -> timeout_evt[1] pulses exactly 32 cycles after entering ON; level then ramps 7->0 over 28 cycles to OFF. Repeat with motion every 20 cycles -> no timeout_evt.
- on_req[2] and off_req[2] same cycle while unlocked, channel OFF -> stays OFF. While RAMP_DOWN at level 3, on_req[2] -> RAMP_UP from 3, reaching 7 after 16 cycles.
- No request for 64 cycles after keypad_ok -> locked=1. Channels 0 and 3 ON, all_off while locked -> both enter RAMP_DOWN next edge.
- Assert reset mid-RAMP_UP at level 4 -> all outputs return to reset values immediately (asynchronously); after release, locked=1.
